// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared operation/flag types and configuration check for pipelined_addsub
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  // Shared with the ALU and the branch unit.
  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

  function automatic bit addsub_cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_segment.sv
// rtl/addsub_segment.sv - one SEG-bit ripple slice with registered sum, carry-out and valid
module addsub_segment
  import addsub_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           adv,
  input  logic           beat,
  input  logic           cin,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  output logic           valid,
  output logic           cout,
  output logic [SEG-1:0] sum
);

  logic [SEG:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= beat;
    end
  end

  // Data registers are don't-care while valid is low, so they carry no reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      cout <= total[SEG];
      sum  <= total[SEG-1:0];
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - segmented-carry pipelined add/sub with ALU flags; ADDSUB_SAT_EN adds in_sat saturation
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
`ifdef ADDSUB_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (!addsub_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  addsub_op_e op;
  logic       adv;

  assign op       = addsub_op_e'(in_sub);
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // op_a/op_b are the operand bits still to be added at the input of stage k;
  // sum is every result bit produced up to and including stage k.
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO  = k * SEG;
    localparam int OPW = WIDTH - LO;

    logic [OPW-1:0]    op_a;
    logic [OPW-1:0]    op_b;
    logic              beat;
    logic              cin;
    logic              valid;
    logic              cout;
    logic [SEG-1:0]    seg_sum;
    logic [LO+SEG-1:0] sum;
`ifdef ADDSUB_SAT_EN
    logic              sat;
`endif

    if (k == 0) begin : g_first
      assign op_a = in_a;
      assign op_b = (op == OP_SUB) ? ~in_b : in_b;
      assign beat = in_valid;
      assign cin  = (op == OP_SUB);
      assign sum  = seg_sum;
`ifdef ADDSUB_SAT_EN
      assign sat  = in_sat;
`endif
    end else begin : g_next
      logic [LO-1:0] low;

      always_ff @(posedge clk) begin
        if (adv) begin
          op_a <= stg[k-1].op_a[OPW+SEG-1:SEG];
          op_b <= stg[k-1].op_b[OPW+SEG-1:SEG];
          low  <= stg[k-1].sum;
`ifdef ADDSUB_SAT_EN
          sat  <= stg[k-1].sat;
`endif
        end
      end

      assign beat = stg[k-1].valid;
      assign cin  = stg[k-1].cout;
      assign sum  = {seg_sum, low};
    end

    addsub_segment #(
      .SEG (SEG)
    ) u_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv),
      .beat  (beat),
      .cin   (cin),
      .a     (op_a[SEG-1:0]),
      .b     (op_b[SEG-1:0]),
      .valid (valid),
      .cout  (cout),
      .sum   (seg_sum)
    );
  end

  // Operand sign bits ride alongside the final segment for the overflow flag.
  logic a_sign;
  logic b_sign;
`ifdef ADDSUB_SAT_EN
  logic sat_q;
`endif

  always_ff @(posedge clk) begin
    if (adv) begin
      a_sign <= stg[LAST].op_a[SEG-1];
      b_sign <= stg[LAST].op_b[SEG-1];
`ifdef ADDSUB_SAT_EN
      sat_q  <= stg[LAST].sat;
`endif
    end
  end

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res;
  alu_flags_t       flags;

  assign raw       = stg[LAST].sum;
  assign out_valid = stg[LAST].valid;

  always_comb begin
    flags.carry = stg[LAST].cout;
    flags.ovf   = (a_sign == b_sign) && (raw[WIDTH-1] != a_sign);
    res         = raw;
`ifdef ADDSUB_SAT_EN
    if (sat_q && flags.ovf) begin
      res = a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    flags.zero  = (res == '0);
    flags.neg   = res[WIDTH-1];
  end

  // Only valid bits are reset, so idle outputs are forced to zero here.
  assign out_sum   = out_valid ? res : '0;
  assign out_carry = out_valid & flags.carry;
  assign out_zero  = out_valid & flags.zero;
  assign out_neg   = out_valid & flags.neg;
  assign out_ovf   = out_valid & flags.ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - directed and streaming checks of pipelined_addsub at 32/4, 64/8 and 32/1
`timescale 1ns/1ps
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        d0_valid, d0_ready, d0_sub, d0_sat, d0_ovalid, d0_oready;
  logic [31:0] d0_a, d0_b, d0_sum;
  logic        d0_carry, d0_zero, d0_neg, d0_ovf;

  logic        d1_valid, d1_ready, d1_sub, d1_ovalid;
  logic [63:0] d1_a, d1_b, d1_sum;
  logic        d1_carry, d1_zero, d1_neg, d1_ovf;

  logic        d2_valid, d2_ready, d2_sub, d2_ovalid;
  logic [31:0] d2_a, d2_b, d2_sum;
  logic        d2_carry, d2_zero, d2_neg, d2_ovf;

  logic [2:0]  ov;
  assign ov = {d2_ovalid, d1_ovalid, d0_ovalid};

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(d0_valid), .in_ready(d0_ready),
    .in_a(d0_a), .in_b(d0_b), .in_sub(d0_sub),
`ifdef ADDSUB_SAT_EN
    .in_sat(d0_sat),
`endif
    .out_valid(d0_ovalid), .out_ready(d0_oready), .out_sum(d0_sum),
    .out_carry(d0_carry), .out_zero(d0_zero), .out_neg(d0_neg), .out_ovf(d0_ovf)
  );

  pipelined_addsub #(.WIDTH(64), .STAGES(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_valid), .in_ready(d1_ready),
    .in_a(d1_a), .in_b(d1_b), .in_sub(d1_sub),
`ifdef ADDSUB_SAT_EN
    .in_sat(1'b0),
`endif
    .out_valid(d1_ovalid), .out_ready(1'b1), .out_sum(d1_sum),
    .out_carry(d1_carry), .out_zero(d1_zero), .out_neg(d1_neg), .out_ovf(d1_ovf)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_valid), .in_ready(d2_ready),
    .in_a(d2_a), .in_b(d2_b), .in_sub(d2_sub),
`ifdef ADDSUB_SAT_EN
    .in_sat(1'b0),
`endif
    .out_valid(d2_ovalid), .out_ready(1'b1), .out_sum(d2_sum),
    .out_carry(d2_carry), .out_zero(d2_zero), .out_neg(d2_neg), .out_ovf(d2_ovf)
  );

  // Reference: plain integer arithmetic; overflow is "true signed result does not fit".
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [32:0] u;
    longint      s;
    logic        c;
    logic        v;
    if (sub) begin
      u = {1'b0, a} - {1'b0, b};
      c = (a >= b);
      s = longint'($signed(a)) - longint'($signed(b));
    end else begin
      u = {1'b0, a} + {1'b0, b};
      c = u[32];
      s = longint'($signed(a)) + longint'($signed(b));
    end
    v = (s != longint'($signed(u[31:0])));
    return {u[31:0], c, (u[31:0] == 32'h0), u[31], v};
  endfunction

  // Presents one beat to the selected DUT (out_ready high, pipeline idle) and
  // counts edges from the capturing edge until out_valid; -1 on timeout.
  task automatic issue(input int which, input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic sat,
                       output logic [63:0] sum, output logic [3:0] fl, output int lat);
    case (which)
      0: begin d0_a = a[31:0]; d0_b = b[31:0]; d0_sub = sub; d0_sat = sat; d0_valid = 1'b1; end
      1: begin d1_a = a; d1_b = b; d1_sub = sub; d1_valid = 1'b1; end
      default: begin d2_a = a[31:0]; d2_b = b[31:0]; d2_sub = sub; d2_valid = 1'b1; end
    endcase
    @(posedge clk); #1;
    d0_valid = 1'b0; d1_valid = 1'b0; d2_valid = 1'b0;
    lat = 1;
    while (!ov[which] && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov[which]) lat = -1;
    case (which)
      0: begin sum = {32'h0, d0_sum}; fl = {d0_carry, d0_zero, d0_neg, d0_ovf}; end
      1: begin sum = d1_sum; fl = {d1_carry, d1_zero, d1_neg, d1_ovf}; end
      default: begin sum = {32'h0, d2_sum}; fl = {d2_carry, d2_zero, d2_neg, d2_ovf}; end
    endcase
    d0_sat = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_cmp++; if (d0_ovalid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", d0_ovalid); end
    n_cmp++; if (d0_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", d0_ready); end
    n_cmp++;
    if ({d0_sum, d0_carry, d0_zero, d0_neg, d0_ovf} !== 36'h0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0", {d0_sum, d0_carry, d0_zero, d0_neg, d0_ovf});
    end
    n_cmp++;
    if ({d1_ovalid, d2_ovalid, d1_ready, d2_ready} !== 4'b0011) begin
      n_bad++; $display("FAIL reset_other_duts got %b want 0011", {d1_ovalid, d2_ovalid, d1_ready, d2_ready});
    end
  endtask

  task automatic test_reset_flush();
    int seen;
    for (int i = 0; i < 4; i++) begin
      d0_a = 32'h100 + i; d0_b = 32'h1; d0_sub = 1'b0; d0_valid = 1'b1;
      @(posedge clk); #1;
    end
    d0_valid = 1'b0;
    n_cmp++; if (d0_ovalid !== 1'b1) begin n_bad++; $display("FAIL flush_pre_valid got %b want 1", d0_ovalid); end
    rst_n = 1'b0; #1;
    n_cmp++; if (d0_ovalid !== 1'b0) begin n_bad++; $display("FAIL flush_async_valid got %b want 0", d0_ovalid); end
    n_cmp++; if (d0_sum !== 32'h0) begin n_bad++; $display("FAIL flush_async_sum got %h want 0", d0_sum); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (d0_ovalid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_no_leftovers got %0d want 0", seen); end
  endtask

  task automatic test_add_wrap();
    logic [63:0] s; logic [3:0] f; int lat;
    issue(0, 64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, s, f, lat);
    n_cmp++; if (s !== 64'h0) begin n_bad++; $display("FAIL add_wrap_sum got %h want 0", s); end
    n_cmp++; if (f !== 4'b1100) begin n_bad++; $display("FAIL add_wrap_flags got %b want 1100", f); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL add_wrap_latency got %0d want 4", lat); end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic [3:0]  fl;
  } vec_t;

  task automatic test_sub_and_overflow();
    vec_t v[4];
    logic [63:0] s; logic [3:0] f; int lat;
    v[0] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 4'b1001};
    v[1] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 4'b0010};
    v[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b0011};
    v[3] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      issue(0, {32'h0, v[i].a}, {32'h0, v[i].b}, v[i].sub, 1'b0, s, f, lat);
      n_cmp++;
      if ({s[31:0], f} !== {v[i].sum, v[i].fl} || lat !== 4) begin
        n_bad++;
        $display("FAIL vec%0d got sum=%h flags=%b lat=%0d want sum=%h flags=%b lat=4",
                 i, s[31:0], f, lat, v[i].sum, v[i].fl);
      end
    end
  endtask

  task automatic test_wide();
    logic [63:0] s; logic [3:0] f; int lat;
    issue(1, 64'h00000000FFFFFFFF, 64'h1, 1'b0, 1'b0, s, f, lat);
    n_cmp++; if (s !== 64'h0000000100000000) begin n_bad++; $display("FAIL wide_sum got %h want 0000000100000000", s); end
    n_cmp++; if (f !== 4'b0000) begin n_bad++; $display("FAIL wide_flags got %b want 0000", f); end
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL wide_latency got %0d want 8", lat); end
    issue(1, 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, s, f, lat);
    n_cmp++; if ({s, f} !== {64'h0, 4'b1100}) begin n_bad++; $display("FAIL wide_wrap got %h/%b want 0/1100", s, f); end
  endtask

  task automatic test_single_stage();
    logic [63:0] s; logic [3:0] f; int lat;
    issue(2, 64'h5, 64'h7, 1'b1, 1'b0, s, f, lat);
    n_cmp++; if ({s[31:0], f} !== {32'hFFFFFFFE, 4'b0010}) begin n_bad++; $display("FAIL single_result got %h/%b want fffffffe/0010", s[31:0], f); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL single_latency got %0d want 1", lat); end
  endtask

`ifdef ADDSUB_SAT_EN
  task automatic test_saturate();
    logic [63:0] s; logic [3:0] f; int lat;
    issue(0, 64'h7FFFFFFF, 64'h1, 1'b0, 1'b1, s, f, lat);
    n_cmp++; if ({s[31:0], f} !== {32'h7FFFFFFF, 4'b0001}) begin n_bad++; $display("FAIL sat_pos got %h/%b want 7fffffff/0001", s[31:0], f); end
    issue(0, 64'h80000000, 64'h1, 1'b1, 1'b1, s, f, lat);
    n_cmp++; if ({s[31:0], f} !== {32'h80000000, 4'b1011}) begin n_bad++; $display("FAIL sat_neg got %h/%b want 80000000/1011", s[31:0], f); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [35:0] exp_q[$];
    logic [35:0] obs, held, e;
    logic        hold;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; hold = 1'b0; held = '0;
    while (got < 100 && cyc < 3000) begin
      d0_oready = ($urandom_range(0, 2) != 0);
      if (sent < 100 && $urandom_range(0, 3) != 0) begin
        d0_valid = 1'b1; d0_a = $urandom; d0_b = $urandom; d0_sub = 1'($urandom_range(0, 1));
      end else begin
        d0_valid = 1'b0;
      end
      @(negedge clk);
      obs = {d0_sum, d0_carry, d0_zero, d0_neg, d0_ovf};
      n_cmp++;
      if (d0_ready !== (!d0_ovalid || d0_oready)) begin
        n_bad++; $display("FAIL stream_in_ready cyc=%0d got %b want %b", cyc, d0_ready, !d0_ovalid || d0_oready);
      end
      if (hold) begin
        n_cmp++;
        if (d0_ovalid !== 1'b1 || obs !== held) begin
          n_bad++; $display("FAIL stream_stall_hold cyc=%0d got %b/%h want 1/%h", cyc, d0_ovalid, obs, held);
        end
      end
      hold = d0_ovalid && !d0_oready;
      held = obs;
      if (d0_ovalid && d0_oready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stream_extra_beat got %h want none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_bad++; $display("FAIL stream_beat%0d got %h want %h", got, obs, e); end
        end
        got++;
      end
      if (d0_valid && d0_ready) begin
        exp_q.push_back(model(d0_a, d0_b, d0_sub));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    d0_valid = 1'b0; d0_oready = 1'b1;
    n_cmp++;
    if (sent !== 100 || got !== 100 || exp_q.size() !== 0) begin
      n_bad++; $display("FAIL stream_count got sent=%0d recv=%0d left=%0d want 100/100/0", sent, got, exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d0_valid = 1'b0; d0_a = '0; d0_b = '0; d0_sub = 1'b0; d0_sat = 1'b0; d0_oready = 1'b1;
    d1_valid = 1'b0; d1_a = '0; d1_b = '0; d1_sub = 1'b0;
    d2_valid = 1'b0; d2_a = '0; d2_b = '0; d2_sub = 1'b0;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_add_wrap();
    test_sub_and_overflow();
    test_wide();
    test_single_stage();
`ifdef ADDSUB_SAT_EN
    test_saturate();
`endif
    test_back_to_back();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor for the execute stage. The carry chain is split into `STAGES` equal ripple segments with a register boundary between segments, so 64-bit or wider datapaths close timing at full clock rate. Operands enter through a valid/ready handshake and leave with the sum and the four ALU flags after a fixed latency. Backpressure stalls the whole pipeline.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width; must be a multiple of `STAGES`.
- `STAGES`, 4: pipeline depth and segment count; 1 ≤ `STAGES` ≤ `WIDTH`; segment width is `SEG` = `WIDTH`/`STAGES`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_a` in `WIDTH`: operand A.
- `in_b` in `WIDTH`: operand B.
- `in_sub` in 1: 0 = A+B; 1 = A−B (B inverted, carry-in 1).
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: consumer accepts a result.
- `out_sum` out `WIDTH`: result.
- `out_carry` out 1: carry out of the MSB. For SUB, 1 = no borrow.
- `out_zero` out 1: `out_sum` == 0.
- `out_neg` out 1: `out_sum[WIDTH-1]`.
- `out_ovf` out 1: signed overflow, computed on the effective B operand.

## Operation
- The global advance signal is `adv = !out_valid || out_ready`. `in_ready = adv`.
- A beat transfers on `in_valid && in_ready`. When `adv` is 0, every stage register holds.
- Stage k (0-based) adds bits [k·SEG +: SEG] of A and effective B, using the carry registered by stage k−1. Stage 0 uses `in_sub` as its carry-in.
- Operand bits not yet consumed and sum bits already produced travel with the beat in skew registers. Each stage carries a valid bit.
- Flags are produced in the last stage from the full sum:
  - `out_carry` is the carry out of the MSB.
  - `out_ovf` = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]).
  - `out_zero` and `out_neg` follow directly from the sum.
- Flags are registered together with `out_sum` and are held stable while `out_valid && !out_ready`.
- The pipeline is fully throughput-capable: one beat per cycle when `out_ready` is held high.
- Stage registers whose valid bit is 0 are don't-care. Only the valid bits are reset.

## Timing
- Reset (async assert, synchronous deassert expected upstream):
  - All valid bits are 0, so `out_valid` = 0 and `in_ready` = 1.
  - `out_sum` = 0 and `out_carry`/`out_zero`/`out_neg`/`out_ovf` = 0.
- Latency: a beat accepted at edge N is presented with `out_valid` = 1 after edge N+`STAGES`, provided no stall occurs.
- Output stall: `out_valid && !out_ready` freezes all stages the same cycle, and `in_ready` drops combinationally.
- Accept and drain in the same cycle (`out_valid && out_ready && in_valid`) is legal, with no bubble.
- Reset mid-operation: every in-flight beat is discarded, and no partial result is ever presented.
- `STAGES` = 1 degenerates to a single registered ripple adder with latency 1.
- Wrap-around: results are modulo 2^`WIDTH`. Examples: 0xFFFFFFFF + 1 gives sum 0 with carry 1; 0 − 1 gives 0xFFFFFFFF with carry 0.

## Configuration
- `ADDSUB_SAT_EN` defined:
  - Adds input `in_sat` (1 bit), which travels with the beat.
  - When `in_sat` = 1 and signed overflow occurs, `out_sum` saturates to the signed maximum (A non-negative) or signed minimum (A negative).
  - `out_ovf` still reports 1. `out_zero` and `out_neg` are computed on the saturated value.
  - `out_carry` is unchanged (raw carry).
- `ADDSUB_SAT_EN` undefined: no `in_sat` port and results always wrap.

## Structure
- Package `addsub_pkg` holds:
  - typedef `addsub_op_e` (`OP_ADD`, `OP_SUB`);
  - packed struct `alu_flags_t` {carry, zero, neg, ovf}, shared with the ALU and the branch unit;
  - elaboration-time checks on `WIDTH` % `STAGES`.
- Sub-module `addsub_segment`: one `SEG`-bit ripple slice with a registered carry-out, registered sum bits and a registered valid bit, sharing `adv`. It is instantiated `STAGES` times in a generate loop.

## Test plan
- Reset with `WIDTH`=32, `STAGES`=4 → `out_valid`=0, `in_ready`=1, all outputs 0; asserting `rst_n` low mid-stream drops the in-flight beats.
- ADD 0xFFFFFFFF + 0x00000001 → sum 0x00000000, carry=1, zero=1, neg=0, ovf=0, valid exactly 4 cycles after acceptance.
- SUB 0x80000000 − 0x00000001 → sum 0x7FFFFFFF, carry=1, ovf=1, neg=0; SUB 5−7 → 0xFFFFFFFE, carry=0, neg=1.
- Back-to-back stream of 100 random beats with `out_ready` toggled randomly → results in order, matching a reference model, none lost or duplicated, and outputs stable during stalls.
- `WIDTH`=64, `STAGES`=8: 0x00000000FFFFFFFF + 1 → 0x0000000100000000 (carry crosses a segment boundary); `STAGES`=1 gives latency 1.
- With `ADDSUB_SAT_EN` and `in_sat`=1: 0x7FFFFFFF + 1 → 0x7FFFFFFF with ovf=1; 0x80000000 − 1 → 0x80000000 with ovf=1.
